// File: rtl/serial_byte_capture.sv
// serial_byte_capture
// Hunts a serial bit stream for a sync pattern, then captures a payload of
// DATA_W bits and one even-parity bit. A good frame loads dout and pulses
// valid; a bad frame pulses perr and leaves dout alone. Bits count only on
// clock edges where en=1.
//
// Handshake: en is a qualifier, not a handshake. There is no back-pressure.
// valid/perr are single-cycle pulses in the cycle after the parity bit is
// consumed, and the consumer must sample them in that cycle.
module serial_byte_capture #(
    parameter int               DATA_W = 8,
    parameter int               SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC  = 4'b1011
) (
    input  logic              c,
    input  logic              rst_n,
    input  logic              din,
    input  logic              en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              perr,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    localparam int FILL_W = $clog2(SYNC_W + 1);
    localparam int CNT_W  = $clog2(DATA_W + 1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_W-1:0]   win_q,   win_d;
    logic [FILL_W-1:0]   fill_q,  fill_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [DATA_W-1:0]   pay_q,   pay_d;
    logic [DATA_W-1:0]   dout_q,  dout_d;
    logic                valid_q, valid_d;
    logic                perr_q,  perr_d;

    // Window and fill as they would be after consuming the current bit.
    logic [SYNC_W-1:0]   win_next;
    logic [FILL_W-1:0]   fill_next;
    logic                sync_hit;
    logic                par_ok;

    // Look-ahead for the sync compare: the match must include the current bit.
    always_comb begin
        win_next  = {win_q[SYNC_W-2:0], din};
        fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        sync_hit  = (win_next == SYNC) && (fill_next == FILL_FULL);
        // Even parity: XOR of payload and parity bit must be zero.
        par_ok    = ~(^pay_q ^ din);
    end

    // State register.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; en=0 holds the current state.
    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                ST_HUNT: if (sync_hit)           state_d = ST_DATA;
                ST_DATA: if (cnt_q == CNT_LAST)  state_d = ST_PAR;
                ST_PAR:                          state_d = ST_HUNT;
                default:                         state_d = ST_HUNT;
            endcase
        end
    end

    // Datapath next values: window/fill, payload shift/count, result pulses.
    always_comb begin
        win_d   = win_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        pay_d   = pay_q;
        dout_d  = dout_q;
        // Pulses drop on every edge unless re-armed by a parity decision.
        valid_d = 1'b0;
        perr_d  = 1'b0;
        if (en) begin
            unique case (state_q)
                ST_HUNT: begin
                    win_d  = win_next;
                    fill_d = fill_next;
                    cnt_d  = '0;
                end
                ST_DATA: begin
                    pay_d = {pay_q[DATA_W-2:0], din};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                ST_PAR: begin
                    if (par_ok) begin
                        dout_d  = pay_q;
                        valid_d = 1'b1;
                    end else begin
                        perr_d  = 1'b1;
                    end
                    // Start the next hunt from an empty window so that payload
                    // and parity bits cannot form part of the next sync.
                    win_d  = '0;
                    fill_d = '0;
                    cnt_d  = '0;
                end
                default: begin
                    win_d  = '0;
                    fill_d = '0;
                    cnt_d  = '0;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            pay_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            win_q   <= win_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        dout        = dout_q;
        valid       = valid_q;
        perr        = perr_q;
        busy        = (state_q != ST_HUNT);
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_serial_byte_capture.sv
// Directed bench for serial_byte_capture with hand-computed expectations.
module tb_serial_byte_capture;

    logic       c;
    logic       rst_n;
    logic       din;
    logic       en;
    logic [7:0] dout;
    logic       valid;
    logic       perr;
    logic       busy;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    serial_byte_capture dut (
        .c           (c),
        .rst_n       (rst_n),
        .din         (din),
        .en          (en),
        .dout        (dout),
        .valid       (valid),
        .perr        (perr),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Clock.
    initial c = 1'b0;
    always #5 c = ~c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one consumed bit; return #1 after the posedge.
    task automatic send(input logic b);
        @(negedge c);
        din = b;
        en  = 1'b1;
        @(posedge c);
        #1;
    endtask

    // One stalled edge with random din.
    task automatic idle();
        @(negedge c);
        din = 1'($urandom_range(0, 1));
        en  = 1'b0;
        @(posedge c);
        #1;
    endtask

    // Send n bits of v, MSB first, checking no pulse appears on any of them.
    task automatic send_bits(input logic [31:0] v, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send(v[i]);
            check({tag, "_quiet"}, {30'd0, valid, perr}, 32'd0);
        end
    endtask

    initial begin
        logic busy_held;
        logic saw_pulse;

        rst_n = 1'b0;
        din   = 1'b0;
        en    = 1'b0;

        // Reset state is asynchronous: visible before any clock edge.
        #2;
        check("rst_dout",  dout,      32'h00);
        check("rst_valid", valid,     32'd0);
        check("rst_perr",  perr,      32'd0);
        check("rst_busy",  busy,      32'd0);
        check("rst_state", dbg_state, 32'd0);
        @(negedge c);
        rst_n = 1'b1;

        // A: good frame 1011 00111100 0.
        send_bits(32'b101, 3, "a_sync");
        check("a_busy_pre", busy, 32'd0);
        send(1'b1);
        check("a_busy_sync", busy, 32'd1);
        send_bits(32'h3C, 8, "a_pay");
        check("a_in_par", dbg_state, 32'd2);
        send(1'b0);
        check("a_dout",  dout,  32'h3C);
        check("a_valid", valid, 32'd1);
        check("a_perr",  perr,  32'd0);
        check("a_busy",  busy,  32'd0);
        idle();
        check("a_valid_1cyc", valid, 32'd0);

        // B: bad parity 1011 00111100 1.
        send_bits(32'b1011, 4, "b_sync");
        send_bits(32'h3C, 8, "b_pay");
        send(1'b1);
        check("b_perr",  perr,  32'd1);
        check("b_valid", valid, 32'd0);
        check("b_dout",  dout,  32'h3C);
        check("b_busy",  busy,  32'd0);
        send(1'b0);
        check("b_perr_1cyc", perr, 32'd0);

        // C: 1011 10000001 0 with 3 stalls after every payload bit.
        send_bits(32'b1011, 4, "c_sync");
        busy_held = 1'b1;
        saw_pulse = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] pv;
            pv = 8'h81;
            send(pv[i]);
            busy_held &= busy;
            saw_pulse |= valid | perr;
            for (int k = 0; k < 3; k++) begin
                idle();
                busy_held &= busy;
                saw_pulse |= valid | perr;
            end
        end
        check("c_busy_held", busy_held, 32'd1);
        check("c_no_early_pulse", saw_pulse, 32'd0);
        check("c_state_par", dbg_state, 32'd2);
        check("c_dout_hold", dout, 32'h3C);
        send(1'b0);
        check("c_dout",  dout,  32'h81);
        check("c_valid", valid, 32'd1);
        idle();
        check("c_valid_once", valid, 32'd0);

        // D: overlapping prefix 1,0,1,0,1,1 then 11111111 0.
        send_bits(32'b10101, 5, "d_pre");
        check("d_no_early_sync", busy, 32'd0);
        send(1'b1);
        check("d_sync_6th", busy, 32'd1);
        send_bits(32'hFF, 8, "d_pay");
        send(1'b0);
        check("d_dout",  dout,  32'hFF);
        check("d_valid", valid, 32'd1);

        // E: reset mid-frame after the 4th payload bit, then 1011 01010101 0.
        send_bits(32'b1011, 4, "e1_sync");
        send_bits(32'b0101, 4, "e1_pay");
        #2;
        rst_n = 1'b0;
        #1;
        check("e_rst_dout",  dout,      32'h00);
        check("e_rst_busy",  busy,      32'd0);
        check("e_rst_state", dbg_state, 32'd0);
        @(negedge c);
        rst_n = 1'b1;
        send_bits(32'b1011, 4, "e2_sync");
        check("e2_busy", busy, 32'd1);
        send_bits(32'h55, 8, "e2_pay");
        send(1'b0);
        check("e2_dout",  dout,  32'h55);
        check("e2_valid", valid, 32'd1);

        // F: fresh sync straight after a parity bit; then a frame whose
        // payload tail plus parity would form part of a sync if not cleared.
        send_bits(32'b101, 3, "f1_sync");
        check("f1_busy_pre", busy, 32'd0);
        send(1'b1);
        check("f1_busy", busy, 32'd1);
        send_bits(32'h02, 8, "f1_pay");
        send(1'b1);
        check("f1_dout",  dout,  32'h02);
        check("f1_valid", valid, 32'd1);
        send(1'b1);
        check("f2_no_false_sync", busy, 32'd0);
        send_bits(32'b011, 3, "f2_sync");
        check("f2_busy", busy, 32'd1);
        send_bits(32'h00, 8, "f2_pay");
        send(1'b0);
        check("f2_dout",  dout,  32'h00);
        check("f2_valid", valid, 32'd1);
        idle();
        check("f2_idle", {30'd0, valid, perr}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_byte_capture.md
SERIAL_BYTE_CAPTURE -- requirements
Module: serial_byte_capture

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload bits per frame (2..16).
REQ-002 The block SHALL have parameter SYNC_W, default 4, meaning sync pattern length (2..8).
REQ-003 The block SHALL have parameter SYNC, default 4'b1011, meaning the sync pattern, first-received bit in the MSB.
REQ-004 The block SHALL have port c, input, 1 bit: the single clock; all state changes on posedge c.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port din, input, 1 bit: serial data from the upstream delay-chain stage, sampled on posedge c.
REQ-007 The block SHALL have port en, input, 1 bit: din qualifier; a bit is consumed only on an edge where en=1.
REQ-008 The block SHALL have port dout, output, DATA_W bits: last good payload, first-received bit in the MSB.
REQ-009 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking a new good payload on dout.
REQ-010 The block SHALL have port perr, output, 1 bit: one-cycle pulse marking a frame discarded for parity error.
REQ-011 The block SHALL have port busy, output, 1 bit: 1 whenever the FSM state is not HUNT.

Function
REQ-012 The frame format SHALL be: SYNC (SYNC_W bits), payload (DATA_W bits, MSB first), 1 parity bit; even parity over payload plus parity bit.
REQ-013 The FSM SHALL have exactly three states: HUNT, DATA and PAR.
REQ-014 Edges with en=0 SHALL leave the FSM state, counters, shift registers and dout unchanged.
REQ-015 In HUNT, each consumed bit SHALL shift into an SYNC_W-bit window (new bit in the LSB) and increment a fill counter that saturates at SYNC_W.
REQ-016 HUNT SHALL move to DATA on the edge where the window including the current bit equals SYNC and fill (including the current bit) equals SYNC_W.
REQ-017 Overlapping prefixes SHALL be honoured: for SYNC=1011, the stream 1,0,1,0,1,1 SHALL match on the 6th bit.
REQ-018 In DATA, the block SHALL shift DATA_W consumed bits into the payload register and count them; the edge consuming bit DATA_W SHALL move the FSM to PAR.
REQ-019 In PAR, the consumed bit SHALL be checked against the payload for even parity.
REQ-020 On a parity pass, the block SHALL load dout from the payload and assert valid on that same edge.
REQ-021 On a parity fail, the block SHALL assert perr and leave dout unchanged.
REQ-022 Either parity outcome SHALL return the FSM to HUNT, with window and fill cleared.
REQ-023 Because the window and fill are cleared, payload or parity bits SHALL never contribute to the next sync match.
REQ-024 Latency SHALL be: valid/perr high in the cycle immediately following the posedge that consumed the parity bit.
REQ-025 valid and perr SHALL each be high for exactly one cycle and SHALL never be high together.
REQ-026 valid and perr SHALL be 0 in every cycle other than those of REQ-024.
REQ-027 Bits presented in HUNT that do not complete a sync SHALL be discarded silently, with no error indication.
REQ-028 The block SHALL apply no timeout; an indefinite en=0 stall in any state SHALL hold all state.

Reset
REQ-029 While rst_n=0, asynchronously and regardless of c: state=HUNT, window=0, fill=0, bit counter=0, payload=0, dout=0, valid=0, perr=0, busy=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no valid/perr pulse; dout SHALL read 0.
REQ-031 On the first posedge after rst_n rises, the block SHALL be in HUNT with empty fill, so that edge's bit SHALL be sync bit 1.

Verification
REQ-032 The bench SHALL check: en=1, bits 1011 00111100 0 -> one cycle after the parity edge, dout=8'h3C, valid=1 for one cycle, perr=0, busy=0.
REQ-033 The bench SHALL check: frame 1011 00111100 1 after a good 8'h3C frame -> perr=1 for one cycle, valid=0, dout stays 8'h3C.
REQ-034 The bench SHALL check: frame 1011 10000001 0 with en=0 for 3 cycles after every payload bit -> dout=8'h81, valid pulses once, busy held high throughout.
REQ-035 The bench SHALL check: stream 1,0,1,0,1,1 then 11111111 0 -> sync matches on the 6th bit, dout=8'hFF, valid=1.
REQ-036 The bench SHALL check: rst_n pulsed low after the 4th payload bit, then a full 1011 01010101 0 frame -> no pulse from the aborted frame, then dout=8'h55, valid=1.
REQ-037 The bench SHALL check: bits 1011 immediately after a completed frame's parity bit -> a fresh sync is detected, and parity/payload bits never match sync.
